// File: rtl/hssl_pkg.sv
// Shared types and constants for the HSSL link supervisor: state encoding,
// sync-state codes and counter widths.
package hssl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_GT_RESET      = 3'd1,
    ST_WAIT_RST_DONE = 3'd2,
    ST_WAIT_SYNC     = 3'd3,
    ST_WAIT_HS       = 3'd4,
    ST_UP            = 3'd5,
    ST_BACKOFF       = 3'd6,
    ST_FAILED        = 3'd7
  } sup_state_e;

  localparam logic [1:0] SYNC_LOST     = 2'b10;
  localparam logic [1:0] SYNC_RESYNC   = 2'b01;
  localparam logic [1:0] SYNC_ACQUIRED = 2'b00;

  localparam int unsigned LINK_DROP_CNT_BITS = 16;
  localparam int unsigned RETRY_CNT_BITS     = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hssl_sup_timer.sv
// Loadable down-counter used as the per-state timeout. It holds at zero once
// expired so a stale expiry stays visible until the next load.
module hssl_sup_timer #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_in,
  input  logic [WIDTH-1:0] value_in,
  output logic             expired_out
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: reload wins, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (load_in) begin
      cnt_d = value_in;
    end else if (cnt_q != {WIDTH{1'b0}}) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_out = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/hssl_link_supervisor.sv
// HSSL link bring-up/recovery FSM: sequences the GT RX reset, waits for sync
// and handshake, retries with backoff and latches permanent failure.
module hssl_link_supervisor
  import hssl_pkg::*;
#(
  parameter int unsigned NUM_CLKC_FOR_GT_RESET = 16,
  parameter int unsigned SYNC_TIMEOUT          = 65536,
  parameter int unsigned HS_TIMEOUT            = 262144,
  parameter int unsigned BACKOFF_CYCLES        = 4096,
  parameter int unsigned MAX_RETRIES           = 7
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable_in,
  input  logic                          clear_stats_in,
  input  logic [1:0]                    loss_of_sync_state_in,
  input  logic                          handshake_complete_in,
  input  logic                          version_mismatch_in,
  input  logic                          gt_reset_done_in,
  output logic                          gt_reset_out,
  output logic                          stop_out,
  output logic                          link_up_out,
  output logic                          fail_out,
  output logic [2:0]                    state_out,
  output logic [RETRY_CNT_BITS-1:0]     retry_cnt_out,
  output logic [LINK_DROP_CNT_BITS-1:0] link_drop_cnt_out
);

  // Timer holds N-1 on entry so that expiry is seen on the Nth cycle in state.
  localparam int unsigned TMR_MAX = max_u(max_u(NUM_CLKC_FOR_GT_RESET, SYNC_TIMEOUT),
                                          max_u(HS_TIMEOUT, BACKOFF_CYCLES));
  localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  sup_state_e                    state_q, state_d;
  logic [RETRY_CNT_BITS-1:0]     retry_q, retry_d;
  logic [LINK_DROP_CNT_BITS-1:0] link_drop_cnt_q, link_drop_cnt_d;
  logic                          gt_reset_q, gt_reset_d;
  logic                          stop_q, stop_d;
  logic                          link_up_q, link_up_d;
  logic                          fail_q, fail_d;
  logic                          attempt_fail_s;
  logic                          drop_event_s;
  logic                          sync_ok_s;
  logic                          tmr_load_s;
  logic [TMR_W-1:0]              tmr_value_s;
  logic                          tmr_expired_s;

  assign sync_ok_s = (loss_of_sync_state_in == SYNC_ACQUIRED);

  hssl_sup_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_in     (tmr_load_s),
    .value_in    (tmr_value_s),
    .expired_out (tmr_expired_s)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      retry_q         <= {RETRY_CNT_BITS{1'b0}};
      link_drop_cnt_q <= {LINK_DROP_CNT_BITS{1'b0}};
    end else begin
      state_q         <= state_d;
      retry_q         <= retry_d;
      link_drop_cnt_q <= link_drop_cnt_d;
    end
  end

  // Next-state, retry accounting and drop detection.
  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    attempt_fail_s = 1'b0;
    drop_event_s   = 1'b0;
    if (!enable_in) begin
      state_d = ST_IDLE;
      retry_d = {RETRY_CNT_BITS{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE:          state_d = ST_GT_RESET;
        ST_GT_RESET:      state_d = tmr_expired_s ? ST_WAIT_RST_DONE : ST_GT_RESET;
        ST_WAIT_RST_DONE: begin
          if (tmr_expired_s)         attempt_fail_s = 1'b1;
          else if (gt_reset_done_in) state_d = ST_WAIT_SYNC;
          else                       state_d = ST_WAIT_RST_DONE;
        end
        ST_WAIT_SYNC: begin
          if (tmr_expired_s)  attempt_fail_s = 1'b1;
          else if (sync_ok_s) state_d = ST_WAIT_HS;
          else                state_d = ST_WAIT_SYNC;
        end
        ST_WAIT_HS: begin
          if (version_mismatch_in)                     state_d = ST_FAILED;
          else if (handshake_complete_in && sync_ok_s) state_d = ST_UP;
          else if (!sync_ok_s || tmr_expired_s)        attempt_fail_s = 1'b1;
          else                                         state_d = ST_WAIT_HS;
        end
        ST_UP: begin
          if (!sync_ok_s || !handshake_complete_in) begin
            drop_event_s = 1'b1;
            state_d      = ST_GT_RESET;
          end else begin
            state_d = ST_UP;
          end
        end
        ST_BACKOFF:       state_d = tmr_expired_s ? ST_GT_RESET : ST_BACKOFF;
        ST_FAILED:        state_d = ST_FAILED;
        default:          state_d = ST_IDLE;
      endcase
      if (attempt_fail_s) begin
        if (retry_q == RETRY_CNT_BITS'(MAX_RETRIES)) begin
          state_d = ST_FAILED;
        end else begin
          retry_d = retry_q + RETRY_CNT_BITS'(1);
          state_d = ST_BACKOFF;
        end
      end else begin
        retry_d = retry_q;
      end
      if ((state_d == ST_UP) && (state_q != ST_UP)) begin
        retry_d = {RETRY_CNT_BITS{1'b0}};
      end else begin
        retry_d = retry_d;
      end
    end
  end

  // Drop statistics: a clear coinciding with a drop leaves exactly one drop.
  always_comb begin
    link_drop_cnt_d = link_drop_cnt_q;
    if (clear_stats_in) begin
      link_drop_cnt_d = drop_event_s ? LINK_DROP_CNT_BITS'(1) : {LINK_DROP_CNT_BITS{1'b0}};
    end else if (drop_event_s && (link_drop_cnt_q != {LINK_DROP_CNT_BITS{1'b1}})) begin
      link_drop_cnt_d = link_drop_cnt_q + LINK_DROP_CNT_BITS'(1);
    end else begin
      link_drop_cnt_d = link_drop_cnt_q;
    end
  end

  // Timer reload on state entry; WAIT_RST_DONE -> WAIT_SYNC shares one window.
  always_comb begin
    tmr_load_s = (state_d != state_q) &&
                 !((state_q == ST_WAIT_RST_DONE) && (state_d == ST_WAIT_SYNC));
    case (state_d)
      ST_GT_RESET:      tmr_value_s = TMR_W'(NUM_CLKC_FOR_GT_RESET - 1);
      ST_WAIT_RST_DONE: tmr_value_s = TMR_W'(SYNC_TIMEOUT - 1);
      ST_WAIT_HS:       tmr_value_s = TMR_W'(HS_TIMEOUT - 1);
      ST_BACKOFF:       tmr_value_s = TMR_W'(BACKOFF_CYCLES - 1);
      default:          tmr_value_s = {TMR_W{1'b0}};
    endcase
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    gt_reset_d = (state_d == ST_GT_RESET);
    stop_d     = (state_d != ST_UP);
    link_up_d  = (state_d == ST_UP);
    fail_d     = (state_d == ST_FAILED);
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gt_reset_q <= 1'b0;
      stop_q     <= 1'b1;
      link_up_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      gt_reset_q <= gt_reset_d;
      stop_q     <= stop_d;
      link_up_q  <= link_up_d;
      fail_q     <= fail_d;
    end
  end

  assign gt_reset_out      = gt_reset_q;
  assign stop_out          = stop_q;
  assign link_up_out       = link_up_q;
  assign fail_out          = fail_q;
  assign state_out         = state_q;
  assign retry_cnt_out     = retry_q;
  assign link_drop_cnt_out = link_drop_cnt_q;

endmodule

// File: tb/tb_hssl_link_supervisor.sv
// Directed self-checking bench for hssl_link_supervisor with shortened timeouts.
module tb_hssl_link_supervisor;
  import hssl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_in;
  logic        clear_stats_in;
  logic [1:0]  loss_of_sync_state_in;
  logic        handshake_complete_in;
  logic        version_mismatch_in;
  logic        gt_reset_done_in;
  logic        gt_reset_out;
  logic        stop_out;
  logic        link_up_out;
  logic        fail_out;
  logic [2:0]  state_out;
  logic [3:0]  retry_cnt_out;
  logic [15:0] link_drop_cnt_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hssl_link_supervisor #(
    .NUM_CLKC_FOR_GT_RESET (16),
    .SYNC_TIMEOUT          (64),
    .HS_TIMEOUT            (256),
    .BACKOFF_CYCLES        (32),
    .MAX_RETRIES           (2)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .enable_in             (enable_in),
    .clear_stats_in        (clear_stats_in),
    .loss_of_sync_state_in (loss_of_sync_state_in),
    .handshake_complete_in (handshake_complete_in),
    .version_mismatch_in   (version_mismatch_in),
    .gt_reset_done_in      (gt_reset_done_in),
    .gt_reset_out          (gt_reset_out),
    .stop_out              (stop_out),
    .link_up_out           (link_up_out),
    .fail_out              (fail_out),
    .state_out             (state_out),
    .retry_cnt_out         (retry_cnt_out),
    .link_drop_cnt_out     (link_drop_cnt_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (state_out == target) break;
    end
    check_eq(tag, 32'(state_out), 32'(target));
  endtask

  // From GT_RESET (reset_done already high, sync lost) to UP.
  task automatic bring_up(input string tag);
    handshake_complete_in = 1'b0;
    loss_of_sync_state_in = SYNC_LOST;
    wait_state({tag, "_wsync"}, ST_WAIT_SYNC, 40);
    loss_of_sync_state_in = SYNC_ACQUIRED;
    wait_state({tag, "_whs"}, ST_WAIT_HS, 4);
    handshake_complete_in = 1'b1;
    wait_state({tag, "_up"}, ST_UP, 4);
  endtask

  initial begin
    int pulse;
    int rises;
    int boff;
    int waitc;
    logic prev;

    reset_n               = 1'b0;
    enable_in             = 1'b0;
    clear_stats_in        = 1'b0;
    loss_of_sync_state_in = SYNC_LOST;
    handshake_complete_in = 1'b0;
    version_mismatch_in   = 1'b0;
    gt_reset_done_in      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(state_out), 32'(ST_IDLE));
    check_eq("rst_gt_reset", 32'(gt_reset_out), 32'd0);
    check_eq("rst_stop", 32'(stop_out), 32'd1);
    check_eq("rst_link_up", 32'(link_up_out), 32'd0);
    check_eq("rst_fail", 32'(fail_out), 32'd0);
    check_eq("rst_retry", 32'(retry_cnt_out), 32'd0);
    check_eq("rst_drops", 32'(link_drop_cnt_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Nominal bring-up.
    enable_in = 1'b1;
    @(negedge clk);
    check_eq("en_latency", 32'(state_out), 32'(ST_GT_RESET));
    pulse = 0;
    for (int i = 0; i < 40; i++) begin
      if (gt_reset_out) pulse++;
      if (state_out == ST_WAIT_RST_DONE) break;
      @(negedge clk);
    end
    check_eq("gt_reset_len", 32'(pulse), 32'd16);
    check_eq("after_gt_reset", 32'(state_out), 32'(ST_WAIT_RST_DONE));
    repeat (4) @(negedge clk);
    gt_reset_done_in = 1'b1;
    @(negedge clk);
    check_eq("to_wait_sync", 32'(state_out), 32'(ST_WAIT_SYNC));
    repeat (29) @(negedge clk);
    loss_of_sync_state_in = SYNC_ACQUIRED;
    @(negedge clk);
    check_eq("to_wait_hs", 32'(state_out), 32'(ST_WAIT_HS));
    repeat (99) @(negedge clk);
    handshake_complete_in = 1'b1;
    @(negedge clk);
    check_eq("to_up", 32'(state_out), 32'(ST_UP));
    check_eq("up_stop", 32'(stop_out), 32'd0);
    check_eq("up_link_up", 32'(link_up_out), 32'd1);
    check_eq("up_retry", 32'(retry_cnt_out), 32'd0);

    // Link drop from UP.
    loss_of_sync_state_in = SYNC_LOST;
    @(negedge clk);
    check_eq("drop_state", 32'(state_out), 32'(ST_GT_RESET));
    check_eq("drop_stop", 32'(stop_out), 32'd1);
    check_eq("drop_link_up", 32'(link_up_out), 32'd0);
    check_eq("drop_gt_reset", 32'(gt_reset_out), 32'd1);
    check_eq("drop_cnt1", 32'(link_drop_cnt_out), 32'd1);
    check_eq("drop_retry", 32'(retry_cnt_out), 32'd0);

    // Clear coinciding with a drop, then a lone clear.
    bring_up("up2");
    loss_of_sync_state_in = SYNC_LOST;
    clear_stats_in        = 1'b1;
    @(negedge clk);
    clear_stats_in = 1'b0;
    check_eq("clear_and_drop", 32'(link_drop_cnt_out), 32'd1);
    clear_stats_in = 1'b1;
    @(negedge clk);
    clear_stats_in = 1'b0;
    check_eq("clear_only", 32'(link_drop_cnt_out), 32'd0);

    // Saturation via backdoor preload.
    bring_up("up3");
    force dut.link_drop_cnt_q = 16'hFFFE;
    #1;
    release dut.link_drop_cnt_q;
    loss_of_sync_state_in = SYNC_LOST;
    @(negedge clk);
    check_eq("drop_to_max", 32'(link_drop_cnt_out), 32'h0000FFFF);
    bring_up("up4");
    loss_of_sync_state_in = SYNC_LOST;
    @(negedge clk);
    check_eq("drop_saturate", 32'(link_drop_cnt_out), 32'h0000FFFF);

    // Version mismatch outranks handshake complete.
    handshake_complete_in = 1'b0;
    wait_state("vm_wsync", ST_WAIT_SYNC, 40);
    loss_of_sync_state_in = SYNC_ACQUIRED;
    wait_state("vm_whs", ST_WAIT_HS, 4);
    version_mismatch_in   = 1'b1;
    handshake_complete_in = 1'b1;
    @(negedge clk);
    version_mismatch_in   = 1'b0;
    handshake_complete_in = 1'b0;
    check_eq("vm_failed", 32'(state_out), 32'(ST_FAILED));
    check_eq("vm_fail_out", 32'(fail_out), 32'd1);
    check_eq("vm_stop", 32'(stop_out), 32'd1);
    pulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (gt_reset_out) pulse++;
    end
    check_eq("vm_no_gt_reset", 32'(pulse), 32'd0);
    check_eq("vm_sticky", 32'(state_out), 32'(ST_FAILED));
    enable_in = 1'b0;
    @(negedge clk);
    check_eq("vm_exit_state", 32'(state_out), 32'(ST_IDLE));
    check_eq("vm_exit_fail", 32'(fail_out), 32'd0);

    // Sync never acquired: three attempts, two backoffs, then FAILED.
    loss_of_sync_state_in = SYNC_LOST;
    enable_in = 1'b1;
    rises = 0; boff = 0; waitc = 0; prev = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (gt_reset_out && !prev) rises++;
      prev = gt_reset_out;
      if (state_out == ST_BACKOFF) boff++;
      if (state_out == ST_WAIT_RST_DONE || state_out == ST_WAIT_SYNC) waitc++;
      if (state_out == ST_FAILED) break;
    end
    check_eq("rt_state", 32'(state_out), 32'(ST_FAILED));
    check_eq("rt_pulses", 32'(rises), 32'd3);
    check_eq("rt_backoff_cycles", 32'(boff), 32'd64);
    check_eq("rt_sync_window", 32'(waitc), 32'd192);
    check_eq("rt_fail_out", 32'(fail_out), 32'd1);
    check_eq("rt_retry", 32'(retry_cnt_out), 32'd2);
    enable_in = 1'b0;
    @(negedge clk);
    check_eq("rt_retry_clr", 32'(retry_cnt_out), 32'd0);

    // Disable while waiting for sync.
    enable_in = 1'b1;
    wait_state("dis_wsync", ST_WAIT_SYNC, 40);
    enable_in = 1'b0;
    @(negedge clk);
    check_eq("dis_state", 32'(state_out), 32'(ST_IDLE));
    check_eq("dis_gt_reset", 32'(gt_reset_out), 32'd0);
    check_eq("dis_stop", 32'(stop_out), 32'd1);
    check_eq("dis_fail", 32'(fail_out), 32'd0);

    // Asynchronous reset in the middle of GT_RESET.
    enable_in = 1'b1;
    wait_state("ar_gt_reset", ST_GT_RESET, 4);
    @(negedge clk);
    check_eq("ar_gt_high", 32'(gt_reset_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_gt_reset", 32'(gt_reset_out), 32'd0);
    check_eq("ar_state", 32'(state_out), 32'(ST_IDLE));
    check_eq("ar_stop", 32'(stop_out), 32'd1);
    check_eq("ar_drops", 32'(link_drop_cnt_out), 32'd0);
    enable_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
